// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture measurement block.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 28
);
  logic             pwm_in;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output pwm_in, clear,
    input  period, high_time, valid, stuck, stuck_level
  );

  modport slave (
    input  pwm_in, clear,
    output period, high_time, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in int_osc clocks,
// with stuck-input detection and saturating counters.
module pwm_capture #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned TIMEOUT_CYC = 2**26
) (
  input  logic         int_osc,
  input  logic         rstn,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_e;

  localparam longint unsigned TO_LAST = longint'(TIMEOUT_CYC) - 64'd1;

  state_e           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_pend_q, hi_pend_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  logic             rise, fall, timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // A counter narrower than the timeout saturates first, so the timeout never fires.
  assign timeout_hit = (state_q != IDLE) && (64'(cnt_q) == TO_LAST);

  always_comb begin
    state_d     = state_q;
    s1_d        = bus.pwm_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    cnt_d       = cnt_inc;
    hi_pend_d   = hi_pend_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    if (bus.clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hi_pend_d = '0;
      period_d  = '0;
      high_d    = '0;
      stuck_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d     = '0;
          hi_pend_d = '0;
          if (rise) begin
            state_d = ARMED;
            stuck_d = 1'b0;
          end
        end
        ARMED, MEAS: begin
          if (rise) begin
            state_d  = MEAS;
            cnt_d    = '0;
            period_d = cnt_inc;
            high_d   = hi_pend_q;
            valid_d  = 1'b1;
          end else if (timeout_hit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            hi_pend_d   = '0;
            stuck_d     = 1'b1;
            stuck_lvl_d = s2_q;
          end else if (fall) begin
            hi_pend_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      hi_pend_q   <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      hi_pend_q   <= hi_pend_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign bus.period      = period_q;
  assign bus.high_time   = high_q;
  assign bus.valid       = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_lvl_q;

endmodule
